stream_demux_buf: RTL and testbench

Registered, parametrised stream demultiplexer. Routes a single valid/ready input stream with payload to one of `N_OUP` output streams, chosen by a select sideband. A two-entry skid buffer cuts every combinational path between `oup_ready_i` and `inp_ready_o` and sustains one transfer per cycle. The block sits between a dispatch stage and its per-target consumers. It adds payload transport, out-of-range drop reporting, a flush, and an occupancy status.

---
 rtl/stream_demux_pkg.sv | 7 +
 rtl/stream_demux_buf_skid.sv | 48 ++++
 rtl/stream_demux_buf.sv | 43 ++++
 tb/tb_stream_demux_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared occupancy encoding and select-range helper
package stream_demux_pkg;
  typedef enum logic [1:0] {FILL_EMPTY, FILL_ONE, FILL_FULL} fill_e;
  function automatic logic sel_legal(input int sel, input int n_oup);
    return sel < n_oup;
  endfunction
endpackage

// File: rtl/stream_demux_buf_skid.sv
// stream_skid_buf: two-entry registered buffer, ready depends only on fill and flush
module stream_skid_buf
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       fill_o
);
  fill_e fill_q, fill_d;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic push, pop;
  assign ready_o = (fill_q != FILL_FULL) & ~flush_i;
  assign valid_o = fill_q != FILL_EMPTY;
  assign push = valid_i & ready_o;
  assign pop = valid_o & ready_i;
  assign data_o = head_q;
  assign fill_o = fill_q;
  always_comb begin
    fill_d = fill_q;
    head_d = head_q;
    tail_d = tail_q;
    case (fill_q)
      FILL_EMPTY: if (push) begin head_d = data_i; fill_d = FILL_ONE; end
      FILL_ONE: begin
        if (push & pop) head_d = data_i;
        else if (push) begin tail_d = data_i; fill_d = FILL_FULL; end
        else if (pop) fill_d = FILL_EMPTY;
      end
      FILL_FULL: if (pop) begin head_d = tail_q; fill_d = FILL_ONE; end
      default: fill_d = FILL_EMPTY;
    endcase
    if (flush_i) fill_d = FILL_EMPTY;
  end
  always_ff @(posedge clk_i) fill_q <= !rst_ni ? FILL_EMPTY : fill_d;
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end
endmodule

// File: rtl/stream_demux_buf.sv
// stream_demux_buf: buffered valid/ready demux with illegal-select drop and flush
module stream_demux_buf
  import stream_demux_pkg::*;
#(
  parameter int N_OUP = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH = $clog2(N_OUP)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  logic [DATA_WIDTH-1:0] inp_data_i,
  input  logic [SEL_WIDTH-1:0]  oup_sel_i,
  output logic [N_OUP-1:0]      oup_valid_o,
  input  logic [N_OUP-1:0]      oup_ready_i,
  output logic [DATA_WIDTH-1:0] oup_data_o,
  output logic                  drop_o,
  output logic [1:0]            fill_o
);
  logic legal, buf_valid, buf_ready, drop_d, drop_q;
  logic [SEL_WIDTH-1:0] head_sel;
  assign legal = sel_legal(int'(oup_sel_i), N_OUP);
  stream_skid_buf #(.WIDTH(SEL_WIDTH + DATA_WIDTH)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (inp_valid_i & legal),
    .ready_o (inp_ready_o),
    .data_i  ({oup_sel_i, inp_data_i}),
    .valid_o (buf_valid),
    .ready_i (buf_ready),
    .data_o  ({head_sel, oup_data_o}),
    .fill_o  (fill_o)
  );
  assign oup_valid_o = {{(N_OUP-1){1'b0}}, buf_valid} << head_sel;
  assign buf_ready = |(oup_ready_i & oup_valid_o);
  // illegal beats are still handshaken so the producer never stalls on them
  assign drop_d = inp_valid_i & inp_ready_o & ~legal;
  always_ff @(posedge clk_i) drop_q <= rst_ni & drop_d;
  assign drop_o = drop_q;
endmodule

// File: tb/tb_stream_demux_buf.sv
// tb_stream_demux_buf: scoreboard-driven checks of the buffered stream demux
module tb_stream_demux_buf;
  logic clk_i = 0, rst_ni, flush_i, inp_valid_i, inp_ready_o, drop_o;
  logic [31:0] inp_data_i, oup_data_o;
  logic [1:0] oup_sel_i, fill_o;
  logic [2:0] oup_valid_o, oup_ready_i;
  int errors = 0, checks = 0, cyc = 0, max_fill = 0;
  int dcount[3] = '{0, 0, 0};
  bit mon_en = 0, exp_drop = 0;
  typedef struct {logic [1:0] sel; logic [31:0] data;} ent_t;
  ent_t q[$];

  stream_demux_buf dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .inp_data_i(inp_data_i),
    .oup_sel_i(oup_sel_i), .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i),
    .oup_data_o(oup_data_o), .drop_o(drop_o), .fill_o(fill_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    logic [2:0] exp_v;
    logic hs;
    if (mon_en) begin
      exp_v = q.size() == 0 ? 3'b000 : 3'b001 << q[0].sel;
      checks++;
      if (fill_o !== 2'(q.size())) begin errors++; $display("FAIL sb_fill: got %0d want %0d", fill_o, q.size()); end
      checks++;
      if (oup_valid_o !== exp_v) begin errors++; $display("FAIL sb_valid: got %b want %b", oup_valid_o, exp_v); end
      if (q.size() > 0) begin
        checks++;
        if (oup_data_o !== q[0].data) begin errors++; $display("FAIL sb_data: got %h want %h", oup_data_o, q[0].data); end
      end
      checks++;
      if (drop_o !== exp_drop) begin errors++; $display("FAIL sb_drop: got %b want %b", drop_o, exp_drop); end
      checks++;
      if (inp_ready_o !== (q.size() < 2 && !flush_i)) begin errors++; $display("FAIL sb_ready: got %b fill %0d flush %b", inp_ready_o, q.size(), flush_i); end
      if (int'(fill_o) > max_fill) max_fill = int'(fill_o);
    end
    if (|(oup_valid_o & oup_ready_i)) begin
      for (int c = 0; c < 3; c++) if (oup_valid_o[c] & oup_ready_i[c]) dcount[c]++;
      if (q.size() > 0) void'(q.pop_front());
    end
    hs = inp_valid_i & inp_ready_o;
    exp_drop = (hs === 1'b1) && oup_sel_i > 2'd2;
    if (hs === 1'b1 && oup_sel_i < 2'd3) q.push_back('{oup_sel_i, inp_data_i});
    if (flush_i) q.delete();
    if (!rst_ni) begin q.delete(); exp_drop = 0; end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] s);
    bit ok = 0;
    inp_valid_i = 1; inp_data_i = d; oup_sel_i = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (inp_ready_o === 1'b1) begin @(posedge clk_i); #1; ok = 1; end
    end
    inp_valid_i = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout: data %h never accepted, want accept within 50 cycles", d); end
  endtask

  task automatic drain();
    bit ok = 0;
    inp_valid_i = 0; flush_i = 0; oup_ready_i = 3'b111;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk_i); #1; ok = fill_o === 2'd0; end
    checks++;
    if (!ok) begin errors++; $display("FAIL drain_timeout: fill %0d want 0", fill_o); end
  endtask

  task automatic test_reset();
    rst_ni = 0; flush_i = 0; inp_valid_i = 1; inp_data_i = 32'hDEAD; oup_sel_i = 0; oup_ready_i = 0;
    repeat (3) begin
      @(posedge clk_i); @(negedge clk_i);
      checks += 3;
      if (oup_valid_o !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", oup_valid_o); end
      if (fill_o !== 2'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_o); end
      if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop_o); end
    end
    @(posedge clk_i); #1;
    rst_ni = 1; inp_valid_i = 0; mon_en = 1;
    @(negedge clk_i);
    checks++;
    if (inp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", inp_ready_o); end
  endtask

  task automatic test_streaming();
    logic [1:0] sels[6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    int b[3], start;
    drain();
    b = dcount; max_fill = 0; start = cyc;
    for (int i = 0; i < 6; i++) send(32'h10 + i, sels[i]);
    checks++;
    if (cyc - start != 6) begin errors++; $display("FAIL stream_rate: took %0d cycles want 6", cyc - start); end
    repeat (2) begin @(posedge clk_i); #1; end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dcount[c] != b[c] + 2) begin errors++; $display("FAIL stream_count: ch%0d got %0d want %0d", c, dcount[c] - b[c], 2); end
    end
    checks++;
    if (max_fill > 1) begin errors++; $display("FAIL stream_fill: max %0d want <=1", max_fill); end
  endtask

  task automatic test_backpressure();
    drain();
    oup_ready_i = 3'b011;
    send(32'hA, 2); send(32'hB, 2);
    inp_valid_i = 1; inp_data_i = 32'hC; oup_sel_i = 2;
    repeat (2) begin
      @(negedge clk_i);
      checks += 4;
      if (inp_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", inp_ready_o); end
      if (fill_o !== 2'd2) begin errors++; $display("FAIL bp_fill: got %0d want 2", fill_o); end
      if (oup_data_o !== 32'hA) begin errors++; $display("FAIL bp_head: got %h want a", oup_data_o); end
      if (oup_valid_o !== 3'b100) begin errors++; $display("FAIL bp_valid: got %b want 100", oup_valid_o); end
    end
    @(posedge clk_i); #1; oup_ready_i = 3'b111;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks += 3;
    if (oup_data_o !== 32'hB) begin errors++; $display("FAIL bp_head_b: got %h want b", oup_data_o); end
    if (fill_o !== 2'd1) begin errors++; $display("FAIL bp_fill_b: got %0d want 1", fill_o); end
    if (inp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b want 1", inp_ready_o); end
    @(posedge clk_i); #1; inp_valid_i = 0;
    @(negedge clk_i);
    checks += 2;
    if (oup_data_o !== 32'hC) begin errors++; $display("FAIL bp_head_c: got %h want c", oup_data_o); end
    if (oup_valid_o !== 3'b100) begin errors++; $display("FAIL bp_valid_c: got %b want 100", oup_valid_o); end
  endtask

  task automatic test_hol();
    int b0, b1;
    drain();
    oup_ready_i = 3'b000;
    send(32'h20, 0); send(32'h21, 1);
    oup_ready_i = 3'b010; b0 = dcount[0]; b1 = dcount[1];
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (oup_valid_o !== 3'b001) begin errors++; $display("FAIL hol_valid: got %b want 001", oup_valid_o); end
    end
    @(posedge clk_i); #1;
    checks++;
    if (dcount[1] != b1) begin errors++; $display("FAIL hol_bypass: ch1 got %0d want 0", dcount[1] - b1); end
    oup_ready_i = 3'b011;
    repeat (2) begin @(posedge clk_i); #1; end
    checks += 2;
    if (dcount[0] != b0 + 1) begin errors++; $display("FAIL hol_ch0: got %0d want 1", dcount[0] - b0); end
    if (dcount[1] != b1 + 1) begin errors++; $display("FAIL hol_ch1: got %0d want 1", dcount[1] - b1); end
  endtask

  task automatic test_illegal();
    drain();
    send(32'hFF, 3);
    @(negedge clk_i);
    checks += 3;
    if (drop_o !== 1'b1) begin errors++; $display("FAIL ill_drop: got %b want 1", drop_o); end
    if (oup_valid_o !== 3'b000) begin errors++; $display("FAIL ill_valid: got %b want 000", oup_valid_o); end
    if (fill_o !== 2'd0) begin errors++; $display("FAIL ill_fill: got %0d want 0", fill_o); end
    @(negedge clk_i);
    checks++;
    if (drop_o !== 1'b0) begin errors++; $display("FAIL ill_pulse: got %b want 0", drop_o); end
    send(32'hFE, 3); send(32'hFD, 3);
    @(negedge clk_i);
    checks++;
    if (drop_o !== 1'b1) begin errors++; $display("FAIL ill_b2b: got %b want 1", drop_o); end
    @(negedge clk_i);
    checks++;
    if (drop_o !== 1'b0) begin errors++; $display("FAIL ill_b2b_end: got %b want 0", drop_o); end
  endtask

  task automatic test_flush();
    drain();
    oup_ready_i = 3'b000;
    send(32'h30, 0); send(32'h31, 1);
    flush_i = 1; inp_valid_i = 1; inp_data_i = 32'h32; oup_sel_i = 3;
    @(negedge clk_i);
    checks += 2;
    if (inp_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", inp_ready_o); end
    if (fill_o !== 2'd2) begin errors++; $display("FAIL flush_pre_fill: got %0d want 2", fill_o); end
    @(posedge clk_i); #1; flush_i = 0; inp_valid_i = 0;
    @(negedge clk_i);
    checks += 3;
    if (fill_o !== 2'd0) begin errors++; $display("FAIL flush_fill: got %0d want 0", fill_o); end
    if (oup_valid_o !== 3'b000) begin errors++; $display("FAIL flush_valid: got %b want 000", oup_valid_o); end
    if (drop_o !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", drop_o); end
  endtask

  task automatic test_midreset();
    drain();
    oup_ready_i = 3'b000;
    send(32'h40, 2);
    rst_ni = 0;
    @(posedge clk_i); #1; rst_ni = 1;
    @(negedge clk_i);
    checks += 2;
    if (oup_valid_o !== 3'b000) begin errors++; $display("FAIL midrst_valid: got %b want 000", oup_valid_o); end
    if (fill_o !== 2'd0) begin errors++; $display("FAIL midrst_fill: got %0d want 0", fill_o); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hol();
    test_illegal();
    test_flush();
    test_midreset();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
